// File: rtl/line_stream_arbiter.sv
// rtl/line_stream_arbiter.sv - two-producer line-granular round-robin token arbiter
module line_stream_arbiter #(
    parameter int LINE_LEN = 512
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] In0_DATA,
    input  logic [15:0] In0_COUNT,
    input  logic        In0_SEND,
    output logic        In0_ACK,
    input  logic [15:0] In1_DATA,
    input  logic [15:0] In1_COUNT,
    input  logic        In1_SEND,
    output logic        In1_ACK,
    output logic [15:0] Out1_DATA,
    output logic [15:0] Out1_COUNT,
    output logic        Out1_SEND,
    input  logic        Out1_RDY,
    input  logic        Out1_ACK,
    output logic [1:0]  GRANT,
    output logic        SRC,
    output logic        LINE_DONE
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY0, S_BUSY1} state_t;

    localparam logic [15:0] LAST_IDX = 16'(LINE_LEN - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic        r_last;
    logic        w_next_last;
    logic [15:0] r_cnt;
    logic [15:0] w_next_cnt;

    logic w_fire0;
    logic w_fire1;
    logic w_fire;
    logic w_line_end;
    logic w_unused;

    // Both requesting: hand the port to whichever source was not served last.
    function automatic state_t arbitrate(input logic s0, input logic s1, input logic last_src);
        if (s0 && s1)
            return last_src ? S_BUSY0 : S_BUSY1;
        else if (s0)
            return S_BUSY0;
        else if (s1)
            return S_BUSY1;
        else
            return S_IDLE;
    endfunction

    assign w_fire0    = (r_state == S_BUSY0) && In0_SEND && Out1_RDY;
    assign w_fire1    = (r_state == S_BUSY1) && In1_SEND && Out1_RDY;
    assign w_fire     = w_fire0 || w_fire1;
    assign w_line_end = w_fire && (r_cnt == LAST_IDX);

    always_comb begin
        w_next_state = r_state;
        w_next_last  = r_last;
        w_next_cnt   = r_cnt;
        if (r_state == S_IDLE) begin
            w_next_state = arbitrate(In0_SEND, In1_SEND, r_last);
        end else if (w_fire) begin
            if (w_line_end) begin
                w_next_cnt   = 16'h0;
                w_next_last  = w_fire1;
                w_next_state = arbitrate(In0_SEND, In1_SEND, w_fire1);
            end else begin
                w_next_cnt = r_cnt + 16'h1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= S_IDLE;
            r_last  <= 1'b1;
            r_cnt   <= 16'h0;
        end else begin
            r_state <= w_next_state;
            r_last  <= w_next_last;
            r_cnt   <= w_next_cnt;
        end
    end

    assign In0_ACK    = w_fire0;
    assign In1_ACK    = w_fire1;
    assign Out1_SEND  = w_fire;
    assign Out1_DATA  = w_fire0 ? In0_DATA : (w_fire1 ? In1_DATA : 16'h0);
    assign Out1_COUNT = {15'h0, w_fire};
    assign GRANT      = {r_state == S_BUSY1, r_state == S_BUSY0};
    assign SRC        = w_fire1;
    assign LINE_DONE  = w_line_end;

    assign w_unused = ^{In0_COUNT, In1_COUNT, Out1_ACK};

endmodule

// File: doc/line_stream_arbiter.md
# line_stream_arbiter

Two-producer, one-consumer token arbiter for the RIPL actor network. It shares one downstream actor input port, such as a horizontal filter stage, between two upstream producer actors. Arbitration is line-granular: once a requester is granted, it keeps the port for exactly LINE_LEN tokens so rows are never interleaved, and the next line goes round-robin. The datapath is combinational pass-through; the grant FSM and line counter are registered.

## Interface
- LINE_LEN, 512: tokens per line (1..65535).
- CLK  in  1  system clock; all state changes on the rising edge.
- RESET  in  1  asynchronous, active-low reset (RESET=0 resets).
- In0_DATA  in  16  producer 0 token.
- In0_COUNT  in  16  producer 0 token count; ignored, treated as 1.
- In0_SEND  in  1  producer 0 has a token.
- In0_ACK  out  1  producer 0 token consumed this cycle.
- In1_DATA, In1_COUNT, In1_SEND, In1_ACK: same as In0_*, for producer 1.
- Out1_DATA  out  16  forwarded token.
- Out1_COUNT  out  16  16'h1 while Out1_SEND=1, else 16'h0.
- Out1_SEND  out  1  token valid this cycle.
- Out1_RDY  in  1  consumer can accept a token this cycle.
- Out1_ACK  in  1  unused; kept for port compatibility.
- GRANT  out  2  one-hot owner: bit0 = In0, bit1 = In1; 2'b00 when idle.
- SRC  out  1  source of the current Out1 token (0/1); 0 when not sending.
- LINE_DONE  out  1  one-cycle pulse on the last token of a line.

## Operation
- States: IDLE, BUSY0, BUSY1.
- Registers:
  - state;
  - last (last-served source);
  - cnt, 16-bit tokens transferred in the current line.
- Transfer fire in BUSYx: InX_SEND & Out1_RDY. Same cycle: InX_ACK=1, Out1_SEND=1, Out1_DATA=InX_DATA, SRC=x. The other In ACK stays 0.
- On each fire, cnt increments. When cnt==LINE_LEN-1 the fire is line-end:
  - LINE_DONE=1;
  - cnt clears to 0;
  - last<=x;
  - next state chosen by arbitration, as below.
- Arbitration, in IDLE or at line-end:
  - only In0_SEND: go to BUSY0;
  - only In1_SEND: go to BUSY1;
  - both: go to the source != last (at line-end, the other source);
  - neither: go to IDLE.
- Arbitration in IDLE never fires a transfer in the same cycle; the grant registers first.
- In BUSYx with no fire, hold state and cnt. An ungranted requester waits; its ACK stays 0.
- LINE_LEN=1: every fire is line-end, so tokens alternate when both sources request.
- When not firing: Out1_DATA=16'h0, Out1_SEND=0, Out1_COUNT=0.
- GRANT decodes state directly.

## Timing
- Reset (RESET=0, asynchronous):
  - state=IDLE, cnt=0, last=1 (In0 wins the first tie);
  - all outputs 0: ACKs, Out1_SEND, Out1_DATA, Out1_COUNT, GRANT, SRC, LINE_DONE.
- Reset deassertion is used synchronously by the FSM; the first arbitration happens on the first edge with RESET=1.
- Reset mid-line: the partial line is abandoned and cnt is lost. There are no ACKs during reset.
- Latency from IDLE: SEND seen at edge n gives GRANT at n+1, and the first fire is possible in cycle n+1.
- Back-to-back lines with no bubble: the line-end fire of BUSY0 at cycle k, with In1_SEND=1 at k, allows an In1 fire at k+1.
- Throughput: 1 token/cycle while the owner sends and Out1_RDY=1.
- Out1_RDY low stalls without loss; ACK is only issued together with Out1_SEND.
- Out1_* and InX_ACK are combinational from SEND/RDY/state; no registered data path.

## Test plan
- Reset/idle. Hold RESET=0 with both SENDs=1 → all outputs 0. After release, cycle 1: GRANT=01, In0_ACK=1, Out1_COUNT=1.
- Single line. LINE_LEN=4, In0 sends 0x10..0x13 continuously, RDY=1 → 4 consecutive Out1_SEND with DATA 0x10..0x13 and SRC=0. LINE_DONE on 0x13 only; then GRANT=00.
- Round-robin tie. LINE_LEN=4, both send continuously → lines alternate In0, In1, In0. Exactly 4 tokens per line, no idle cycle between lines, LINE_DONE every 4th token.
- Backpressure. Toggle Out1_RDY 1,0,1,0 mid-line → ACK/SEND only on RDY=1 cycles. cnt holds; line completes after 4 fires. In1 is never ACKed during the line.
- Reset mid-line. Assert RESET after 2 of 4 tokens from In1, then release with both requesting → GRANT=01 (In0 wins via last=1). cnt restarts, full 4-token line.
- LINE_LEN=1. Both send → SRC alternates 0,1,0,1 every cycle with LINE_DONE=1 each fire.
